// File: rtl/game_console_top.sv
// game_console_top: single-player console. A 25 MHz pixel enable is derived
// from the 100 MHz clk and drives 640x480@60 VGA timing. A PS/2 receiver and
// key decoder feed a player square that moves once per frame.
// Ports:
//   clk                     100 MHz system clock
//   reset_n                 asynchronous active-low reset
//   ps2_clk, ps2_data       PS/2 keyboard lines (idle high, asynchronous)
//   vga_hsync, vga_vsync    active-low syncs, one pixel behind the counters
//   vga_r, vga_g, vga_b     4-bit colour channels
module game_console_top #(
  parameter int H_VISIBLE   = 640,
  parameter int V_VISIBLE   = 480,
  parameter int PLAYER_SIZE = 16,
  parameter int STEP        = 2,
  parameter int PS2_TIMEOUT = 131072,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] BORDER   = 10'd4;
  localparam logic [9:0] H_BORDER = 10'(H_VISIBLE - 4);
  localparam logic [9:0] V_BORDER = 10'(V_VISIBLE - 4);
  localparam logic [9:0] X_MAX    = 10'(H_VISIBLE - PLAYER_SIZE);
  localparam logic [9:0] Y_MAX    = 10'(V_VISIBLE - PLAYER_SIZE);
  localparam logic [9:0] X_INIT   = 10'((H_VISIBLE - PLAYER_SIZE) / 2);
  localparam logic [9:0] Y_INIT   = 10'((V_VISIBLE - PLAYER_SIZE) / 2);
  localparam logic [10:0] PSIZE   = 11'(PLAYER_SIZE);
  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam int TW = $clog2(PS2_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(PS2_TIMEOUT - 1);

  // Pixel enable
  logic [1:0] div;
  logic       pix_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div <= '0;
    else          div <= div + 2'd1;
  end

  assign pix_en = (div == 2'd3);

  // VGA timing
  logic [9:0] h_count, v_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_en) begin
      if (h_count == H_LAST) begin
        h_count <= '0;
        v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
      end else begin
        h_count <= h_count + 10'd1;
      end
    end
  end

  // Colour selection
  logic [9:0]  player_x, player_y;
  logic [11:0] rgb;
  logic        visible, border, player;

  always_comb begin
    visible = (h_count < H_VIS) && (v_count < V_VIS);
    border  = (h_count < BORDER) || (h_count >= H_BORDER) ||
              (v_count < BORDER) || (v_count >= V_BORDER);
    player  = ({1'b0, h_count} >= {1'b0, player_x}) &&
              ({1'b0, h_count} <  {1'b0, player_x} + PSIZE) &&
              ({1'b0, v_count} >= {1'b0, player_y}) &&
              ({1'b0, v_count} <  {1'b0, player_y} + PSIZE);
    rgb = '0;
    if (!visible)    rgb = '0;
    else if (border) rgb = 12'hFFF;
    else if (player) rgb = 12'hFF0;
    else             rgb = 12'h004;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      {vga_r, vga_g, vga_b} <= '0;
    end else if (pix_en) begin
      vga_hsync <= !((h_count >= HS_START) && (h_count < HS_END));
      vga_vsync <= !((v_count >= VS_START) && (v_count < VS_END));
      {vga_r, vga_g, vga_b} <= rgb;
    end
  end

  // PS/2 receiver
  logic [2:0]    ps2c_sync, ps2d_sync;
  logic          ps2c_prev, ps2_fall;
  logic [3:0]    bit_cnt;
  logic [9:0]    rx_shift;
  logic [10:0]   rx_frame;
  logic          frame_ok;
  logic [TW-1:0] idle_cnt;
  logic          byte_valid;
  logic [7:0]    rx_byte;

  // rx_frame is the complete frame as it stands when the 11th bit arrives
  assign ps2_fall = ps2c_prev & ~ps2c_sync[2];
  assign rx_frame = {ps2d_sync[2], rx_shift};
  assign frame_ok = !rx_frame[0] && rx_frame[10] && (^rx_frame[9:1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps2c_sync  <= '1;
      ps2d_sync  <= '1;
      ps2c_prev  <= 1'b1;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
    end else begin
      ps2c_sync  <= {ps2c_sync[1:0], ps2_clk};
      ps2d_sync  <= {ps2d_sync[1:0], ps2_data};
      ps2c_prev  <= ps2c_sync[2];
      byte_valid <= 1'b0;
      if (ps2_fall) begin
        idle_cnt <= '0;
        rx_shift <= {ps2d_sync[2], rx_shift[9:1]};
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            rx_byte    <= rx_frame[8:1];
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != '0) begin
        if (idle_cnt == TO_LAST) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  // Key decoder
  logic ext, brk, key_up, key_down, key_left, key_right;
  logic hit_up, hit_down, hit_left, hit_right;

  always_comb begin
    hit_up    = ext ? (rx_byte == 8'h75) : (rx_byte == 8'h1D);
    hit_down  = ext ? (rx_byte == 8'h72) : (rx_byte == 8'h1B);
    hit_left  = ext ? (rx_byte == 8'h6B) : (rx_byte == 8'h1C);
    hit_right = ext ? (rx_byte == 8'h74) : (rx_byte == 8'h23);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {ext, brk, key_up, key_down, key_left, key_right} <= '0;
    end else if (byte_valid) begin
      if (rx_byte == 8'hE0) begin
        ext <= 1'b1;
      end else if (rx_byte == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        if (hit_up)    key_up    <= !brk;
        if (hit_down)  key_down  <= !brk;
        if (hit_left)  key_left  <= !brk;
        if (hit_right) key_right <= !brk;
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  // Game update, once per frame at the first pixel of the first blank line
  logic signed [11:0] dx, dy, nx, ny;
  logic [9:0]         x_next, y_next;
  logic               frame_tick;

  always_comb begin
    dx = '0;
    dy = '0;
    if (key_right) dx = dx + STEP_S;
    if (key_left)  dx = dx - STEP_S;
    if (key_down)  dy = dy + STEP_S;
    if (key_up)    dy = dy - STEP_S;
    nx = $signed({2'b00, player_x}) + dx;
    ny = $signed({2'b00, player_y}) + dy;
    if (nx < 0)                            x_next = '0;
    else if (nx > $signed({2'b00, X_MAX})) x_next = X_MAX;
    else                                   x_next = nx[9:0];
    if (ny < 0)                            y_next = '0;
    else if (ny > $signed({2'b00, Y_MAX})) y_next = Y_MAX;
    else                                   y_next = ny[9:0];
    frame_tick = pix_en && (h_count == '0) && (v_count == V_VIS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      player_x <= X_INIT;
      player_y <= Y_INIT;
    end else if (frame_tick) begin
      player_x <= x_next;
      player_y <= y_next;
    end
  end

endmodule

// File: tb/tb_game_console_top.sv
// tb_game_console_top: directed bench for game_console_top on a reduced
// 24x20 visible screen (32x24 total) so whole frames stay short. With an
// 8-pixel player and STEP=4 the player starts at x=8, y=6 and clamps at
// x 0..16, y 0..12. PS/2 bits last 40 clk; the idle timeout is 200 clk.
module tb_game_console_top;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic vga_hsync, vga_vsync;
  logic [3:0] vga_r, vga_g, vga_b;

  int checks = 0;
  int errors = 0;

  game_console_top #(
    .H_VISIBLE(24), .V_VISIBLE(20), .PLAYER_SIZE(8), .STEP(4), .PS2_TIMEOUT(200),
    .H_FRONT(2), .H_SYNC(4), .H_BACK(2), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         h;
    int         v;
    logic [11:0] rgb;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait until an output reaches a level, sampled 1 time unit after posedge.
  task automatic wait_sig(input bit use_vs, input logic val, output longint t);
    for (int n = 0; n < 8000; n++) begin
      @(posedge clk);
      #1;
      if ((use_vs ? vga_vsync : vga_hsync) === val) begin
        t = $time;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_%s: got timeout expected level %0b", use_vs ? "vsync" : "hsync", val);
    t = $time;
  endtask

  task automatic wait_vsync();
    longint t;
    wait_sig(1'b1, 1'b1, t);
    wait_sig(1'b1, 1'b0, t);
  endtask

  task automatic sample_at(input int h, input int v);
    int n;
    for (n = 0; n < 8000; n++) begin
      @(negedge clk);
      if (dut.pix_en && dut.h_count == 10'(h) && dut.v_count == 10'(v)) break;
    end
    if (n == 8000) begin
      checks++;
      errors++;
      $display("FAIL sample_%0d_%0d: got timeout expected pixel", h, v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    #100;
    ps2_clk = 1'b0;
    #200;
    ps2_clk = 1'b1;
    #100;
  endtask

  task automatic ps2_send(input logic [7:0] d, input logic bad_par);
    logic p;
    p = (~^d) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    #1000;
  endtask

  initial begin
    longint t0, t1, t2;
    string  nm;

    vecs[0]  = '{0,  0,  12'hFFF, 1'b1, 1'b1};
    vecs[1]  = '{10, 3,  12'hFFF, 1'b1, 1'b1};
    vecs[2]  = '{10, 4,  12'h004, 1'b1, 1'b1};
    vecs[3]  = '{24, 5,  12'h000, 1'b1, 1'b1};
    vecs[4]  = '{25, 5,  12'h000, 1'b1, 1'b1};
    vecs[5]  = '{26, 5,  12'h000, 1'b0, 1'b1};
    vecs[6]  = '{29, 5,  12'h000, 1'b0, 1'b1};
    vecs[7]  = '{30, 5,  12'h000, 1'b1, 1'b1};
    vecs[8]  = '{7,  6,  12'h004, 1'b1, 1'b1};
    vecs[9]  = '{8,  6,  12'hFF0, 1'b1, 1'b1};
    vecs[10] = '{3,  10, 12'hFFF, 1'b1, 1'b1};
    vecs[11] = '{4,  10, 12'h004, 1'b1, 1'b1};
    vecs[12] = '{19, 10, 12'h004, 1'b1, 1'b1};
    vecs[13] = '{20, 10, 12'hFFF, 1'b1, 1'b1};
    vecs[14] = '{15, 13, 12'hFF0, 1'b1, 1'b1};
    vecs[15] = '{16, 13, 12'h004, 1'b1, 1'b1};
    vecs[16] = '{8,  14, 12'h004, 1'b1, 1'b1};
    vecs[17] = '{10, 15, 12'h004, 1'b1, 1'b1};
    vecs[18] = '{10, 16, 12'hFFF, 1'b1, 1'b1};
    vecs[19] = '{5,  20, 12'h000, 1'b1, 1'b1};
    vecs[20] = '{5,  21, 12'h000, 1'b1, 1'b0};
    vecs[21] = '{5,  22, 12'h000, 1'b1, 1'b0};
    vecs[22] = '{5,  23, 12'h000, 1'b1, 1'b1};

    // Reset held
    #12;
    check("rst_hsync", 32'(vga_hsync), 1);
    check("rst_vsync", 32'(vga_vsync), 1);
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    check("rst_x", 32'(dut.player_x), 8);
    check("rst_y", 32'(dut.player_y), 6);

    // Release between edges; pix_en first seen on the 4th edge
    #10;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pix_en_first", 32'(dut.pix_en), 1);
    check("h_before_en", 32'(dut.h_count), 0);
    @(posedge clk);
    #1;
    check("h_after_en", 32'(dut.h_count), 1);

    // Frame image
    for (int i = 0; i < 23; i++) begin
      sample_at(vecs[i].h, vecs[i].v);
      nm = $sformatf("rgb_h%0d_v%0d", vecs[i].h, vecs[i].v);
      check(nm, 32'({vga_r, vga_g, vga_b}), 32'(vecs[i].rgb));
      nm = $sformatf("hs_h%0d_v%0d", vecs[i].h, vecs[i].v);
      check(nm, 32'(vga_hsync), 32'(vecs[i].hs));
      nm = $sformatf("vs_h%0d_v%0d", vecs[i].h, vecs[i].v);
      check(nm, 32'(vga_vsync), 32'(vecs[i].vs));
    end

    // Line and frame timing: 32 pixels x 4 clk x 10 units per line
    wait_sig(1'b0, 1'b1, t0);
    wait_sig(1'b0, 1'b0, t0);
    wait_sig(1'b0, 1'b1, t1);
    wait_sig(1'b0, 1'b0, t2);
    check("hsync_low", 32'(t1 - t0), 160);
    check("hsync_period", 32'(t2 - t0), 1280);
    wait_sig(1'b1, 1'b1, t0);
    wait_sig(1'b1, 1'b0, t0);
    wait_sig(1'b1, 1'b1, t1);
    wait_sig(1'b1, 1'b0, t2);
    check("vsync_low", 32'(t1 - t0), 2560);
    check("vsync_period", 32'(t2 - t0), 30720);

    // Up key, then release
    wait_vsync();
    ps2_send(8'h1D, 1'b0);
    wait_vsync();
    check("up_y", 32'(dut.player_y), 2);
    check("up_x", 32'(dut.player_x), 8);
    ps2_send(8'hF0, 1'b0);
    ps2_send(8'h1D, 1'b0);
    wait_vsync();
    check("up_release_y", 32'(dut.player_y), 2);

    // Down key held into the bottom clamp
    ps2_send(8'h1B, 1'b0);
    wait_vsync();
    check("down1_y", 32'(dut.player_y), 6);
    wait_vsync();
    check("down2_y", 32'(dut.player_y), 10);
    wait_vsync();
    check("down_clamp_y", 32'(dut.player_y), 12);
    wait_vsync();
    check("down_hold_y", 32'(dut.player_y), 12);
    ps2_send(8'hF0, 1'b0);
    ps2_send(8'h1B, 1'b0);
    wait_vsync();
    check("down_release_y", 32'(dut.player_y), 12);

    // Extended left arrow into the left clamp, then extended release
    ps2_send(8'hE0, 1'b0);
    ps2_send(8'h6B, 1'b0);
    wait_vsync();
    check("left1_x", 32'(dut.player_x), 4);
    wait_vsync();
    check("left2_x", 32'(dut.player_x), 0);
    wait_vsync();
    check("left_clamp_x", 32'(dut.player_x), 0);
    ps2_send(8'hE0, 1'b0);
    ps2_send(8'hF0, 1'b0);
    ps2_send(8'h6B, 1'b0);
    wait_vsync();
    check("left_release_x", 32'(dut.player_x), 0);

    // Bad parity ignored; abandoned partial frame cleared by the timeout
    ps2_send(8'h1D, 1'b1);
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    ps2_data = 1'b1;
    #4000;
    ps2_send(8'h23, 1'b0);
    wait_vsync();
    check("err_y", 32'(dut.player_y), 12);
    check("right1_x", 32'(dut.player_x), 4);
    wait_vsync();
    check("right2_x", 32'(dut.player_x), 8);
    wait_vsync();
    check("right3_x", 32'(dut.player_x), 12);

    // Asynchronous reset in the middle of an hsync pulse
    wait_sig(1'b0, 1'b1, t0);
    wait_sig(1'b0, 1'b0, t0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_hsync", 32'(vga_hsync), 1);
    check("async_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    check("async_x", 32'(dut.player_x), 8);
    check("async_y", 32'(dut.player_y), 6);
    check("async_h", 32'(dut.h_count), 0);
    #20;
    reset_n = 1'b1;
    #100;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
